// File: rtl/rr_counter_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rr_counter_scheduler
// Purpose  : Round-robin arbiter sharing one saturating up-counter among N
//            requesters. Each grant increments the counter by one; the
//            counter holds at LIMIT until cleared.
// Revision : 1.0 - initial release
// ============================================================================
module rr_counter_scheduler #(
  parameter int               N     = 4,
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] LIMIT = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             clear,
  output logic [N-1:0]     grant,
  output logic [WIDTH-1:0] counter,
  output logic             saturated,
  output logic             busy
);

  // Pointer width; a single requester still needs one (constant) bit.
  localparam int C_PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SAT   = 2'd2
  } state_t;

  // With LIMIT == 0 the counter already sits at its bound after reset/clear,
  // so the idle state is the saturated one.
  localparam state_t C_REST_STATE = (LIMIT == '0) ? ST_SAT : ST_IDLE;

  state_t           r_state;
  logic [C_PW-1:0]  r_ptr;
  logic [N-1:0]     r_grant;
  logic [WIDTH-1:0] r_counter;

  logic [2*N-1:0]   w_req2;
  logic [N-1:0]     w_rot;
  logic             w_found;
  logic [C_PW-1:0]  w_off;
  logic [C_PW:0]    w_sum;
  logic [C_PW-1:0]  w_winner;
  logic [C_PW-1:0]  w_ptr_nxt;
  logic [N-1:0]     w_onehot;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_can_grant;

  // Rotate requests so the pointer position lands at bit 0, then take the
  // lowest set bit; the winner index is pointer + offset, wrapped modulo N.
  always_comb begin
    w_req2  = {req, req} >> r_ptr;
    w_rot   = w_req2[N-1:0];
    w_found = |req;
    w_off   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off = C_PW'(j);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (C_PW + 1)'(N)) begin
      w_sum = w_sum - (C_PW + 1)'(N);
    end
    w_winner    = w_sum[C_PW-1:0];
    w_ptr_nxt   = (w_winner == C_PW'(N - 1)) ? '0 : w_winner + 1'b1;
    w_onehot    = N'(1) << w_winner;
    w_cnt_inc   = r_counter + 1'b1;
    // Counter below LIMIT guarantees the increment can never wrap.
    w_can_grant = w_found && (r_state != ST_SAT) && (r_counter < LIMIT);
  end

  // Control FSM with registered grant, counter and pointer; reset beats
  // clear, clear beats arbitration (a request seen with clear waits a cycle).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_counter <= '0;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_state   <= C_REST_STATE;
    end else if (clear) begin
      r_counter <= '0;
      r_grant   <= '0;
      r_state   <= C_REST_STATE;
    end else if (w_can_grant) begin
      r_grant   <= w_onehot;
      r_counter <= w_cnt_inc;
      r_ptr     <= w_ptr_nxt;
      r_state   <= (w_cnt_inc == LIMIT) ? ST_SAT : ST_COUNT;
    end else begin
      r_grant <= '0;
      if (r_state == ST_COUNT) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign grant     = r_grant;
  assign counter   = r_counter;
  assign saturated = (r_state == ST_SAT);
  assign busy      = (r_state == ST_COUNT);

  // Safety properties.
  p_onehot : assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(grant));

  p_bound : assert property (@(posedge clock) disable iff (!reset_n)
    counter <= LIMIT);

  // The grant that reaches LIMIT is still visible in the first saturated
  // cycle, so the no-grant guarantee applies from the following cycle on.
  p_sat : assert property (@(posedge clock) disable iff (!reset_n)
    saturated |=> (grant == '0));

`ifdef FORMAL
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_fair
      a_hold : assume property (@(posedge clock) disable iff (!reset_n)
        req[gi] && !grant[gi] |=> req[gi]);

      p_fair : assert property (@(posedge clock) disable iff (!reset_n)
        req[gi] && !saturated && !clear |->
          ##[1:N] (grant[gi] || saturated || clear));

      a_clear_fair : assume property (@(posedge clock) disable iff (!reset_n)
        saturated |-> s_eventually clear);

      p_live : assert property (@(posedge clock) disable iff (!reset_n)
        req[gi] |-> s_eventually grant[gi]);
    end
  endgenerate
`endif

endmodule
`default_nettype wire
